// File: rtl/tagger_lookup_seq.sv
// tagger_lookup_seq: partition-tag lookup, scanning PMP-style region entries one per cycle
// through a single shared matcher; the lowest-index hit supplies the patid.
module tagger_patid #(
    parameter int ADDR_LEN    = 48,
    parameter int TAGGER_GRAN = 2
) (
    input  logic [ADDR_LEN-1:0] prev,
    input  logic [ADDR_LEN-1:0] curr,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [1:0]          mode,
    output logic                match
);
    logic [ADDR_LEN-1:0] gmask, nmask;
    always_comb begin
        gmask = {ADDR_LEN{1'b1}} << TAGGER_GRAN;
        // NAPOT size is encoded by trailing ones: curr^(curr+1) covers them plus the first zero
        nmask = ~(curr ^ (curr + 1'b1)) & gmask;
        match = mode == 2'd1 ? (addr >= prev && addr < curr) :
                mode == 2'd2 ? ((addr ^ curr) & gmask) == '0 :
                mode == 2'd3 ? ((addr ^ curr) & nmask) == '0 : 1'b0;
    end
endmodule

module tagger_lookup_seq #(
    parameter int ADDR_LEN      = 48,
    parameter int MAXPARTITION  = 8,
    parameter int TAGGER_GRAN   = 2,
    parameter int PATID_LEN     = 3,
    parameter int DEFAULT_PATID = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_we_i,
    output logic                            cfg_gnt_o,
    input  logic [$clog2(MAXPARTITION)-1:0] cfg_idx_i,
    input  logic [ADDR_LEN-1:0]             cfg_addr_i,
    input  logic [1:0]                      cfg_mode_i,
    input  logic [PATID_LEN-1:0]            cfg_patid_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [ADDR_LEN-1:0]             req_addr_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [PATID_LEN-1:0]            rsp_patid_o,
    output logic                            rsp_hit_o,
    output logic                            busy_o
);
    localparam int IW = $clog2(MAXPARTITION);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
    state_t state, state_d;
    logic [IW-1:0] idx;
    logic [ADDR_LEN-1:0] req_addr, prev;
    logic [ADDR_LEN-1:0] addr_q [MAXPARTITION];
    logic [1:0] mode_q [MAXPARTITION];
    logic [PATID_LEN-1:0] patid_q [MAXPARTITION];
    logic match, last, idx_ok;

    assign cfg_gnt_o   = state == IDLE;
    assign req_ready_o = state == IDLE;
    assign rsp_valid_o = state == RESP;
    assign busy_o      = state != IDLE;
    assign last        = {1'b0, idx} == (IW+1)'(MAXPARTITION - 1);
    assign idx_ok      = {1'b0, cfg_idx_i} < (IW+1)'(MAXPARTITION);
    assign prev        = idx == '0 ? '0 : addr_q[idx - 1'b1];

    tagger_patid #(.ADDR_LEN(ADDR_LEN), .TAGGER_GRAN(TAGGER_GRAN)) u_match (
        .prev(prev),
        .curr(addr_q[idx]),
        .addr(req_addr),
        .mode(mode_q[idx]),
        .match(match)
    );

    always_comb begin
        state_d = state == IDLE ? (req_valid_i ? SCAN : IDLE) :
                  state == SCAN ? ((match || last) ? RESP : SCAN) :
                  (rsp_ready_i ? IDLE : RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            req_addr    <= '0;
            rsp_patid_o <= '0;
            rsp_hit_o   <= 1'b0;
            for (int i = 0; i < MAXPARTITION; i++) begin
                addr_q[i]  <= '0;
                mode_q[i]  <= 2'd0;
                patid_q[i] <= '0;
            end
        end else begin
            state <= state_d;
            if (cfg_we_i && cfg_gnt_o && idx_ok) begin
                addr_q[cfg_idx_i]  <= cfg_addr_i;
                mode_q[cfg_idx_i]  <= cfg_mode_i;
                patid_q[cfg_idx_i] <= cfg_patid_i;
            end
            if (state == IDLE && req_valid_i) begin
                req_addr <= req_addr_i;
                idx      <= '0;
            end
            if (state == SCAN) begin
                if (match) begin
                    rsp_patid_o <= patid_q[idx];
                    rsp_hit_o   <= 1'b1;
                end else if (last) begin
                    rsp_patid_o <= PATID_LEN'(DEFAULT_PATID);
                    rsp_hit_o   <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tagger_lookup_seq.sv
// tb_tagger_lookup_seq: directed table of lookups plus hand sequences for
// backpressure, simultaneous write/accept and mid-scan reset.
module tb_tagger_lookup_seq;
    logic clk_i = 1'b0;
    logic rst_i, cfg_we_i, cfg_gnt_o, req_valid_i, req_ready_o;
    logic rsp_valid_o, rsp_ready_i, rsp_hit_o, busy_o;
    logic [2:0] cfg_idx_i, cfg_patid_i, rsp_patid_o;
    logic [47:0] cfg_addr_i, req_addr_i;
    logic [1:0] cfg_mode_i;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [47:0] addr;
        logic [2:0]  patid;
        logic        hit;
        int          lat;
        string       name;
    } vec_t;
    vec_t tbl [11];

    tagger_lookup_seq dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_we_i(cfg_we_i), .cfg_gnt_o(cfg_gnt_o), .cfg_idx_i(cfg_idx_i),
        .cfg_addr_i(cfg_addr_i), .cfg_mode_i(cfg_mode_i), .cfg_patid_i(cfg_patid_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_patid_o(rsp_patid_o), .rsp_hit_o(rsp_hit_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] i, input logic [47:0] a, input logic [1:0] m, input logic [2:0] p);
        cfg_we_i = 1'b1; cfg_idx_i = i; cfg_addr_i = a; cfg_mode_i = m; cfg_patid_i = p;
        @(posedge clk_i); #1;
        cfg_we_i = 1'b0;
        @(negedge clk_i);
    endtask

    // Called at a negedge in IDLE; returns at a negedge.
    task automatic lookup(input logic [47:0] a, input logic [2:0] ep, input logic eh,
                          input int el, input string nm, input bit hs);
        int lat = 0;
        bit seen = 0;
        req_valid_i = 1'b1; req_addr_i = a;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; cfg_we_i = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk_i); lat++;
            @(negedge clk_i); seen = rsp_valid_o;
        end
        check({nm, " latency"}, lat, el);
        check({nm, " patid"}, rsp_patid_o, ep);
        check({nm, " hit"}, rsp_hit_o, eh);
        if (hs) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check({nm, " idle after handshake"}, {rsp_valid_o, req_ready_o}, 2'b01);
        end
    endtask

    initial begin
        rst_i = 1'b1; cfg_we_i = 0; cfg_idx_i = 0; cfg_addr_i = 0; cfg_mode_i = 0; cfg_patid_i = 0;
        req_valid_i = 0; req_addr_i = 0; rsp_ready_i = 1'b1;
        tbl[0]  = '{48'h0800, 3'd3, 1'b1, 1, "tor_e0"};
        tbl[1]  = '{48'h0FFF, 3'd3, 1'b1, 1, "tor_e0_top"};
        tbl[2]  = '{48'h1000, 3'd5, 1'b1, 2, "tor_e1_base"};
        tbl[3]  = '{48'h1800, 3'd5, 1'b1, 2, "tor_e1"};
        tbl[4]  = '{48'h2000, 3'd0, 1'b0, 8, "tor_e1_end_miss"};
        tbl[5]  = '{48'h4ABC, 3'd6, 1'b1, 3, "napot"};
        tbl[6]  = '{48'h4000, 3'd6, 1'b1, 3, "napot_base"};
        tbl[7]  = '{48'h4FFF, 3'd6, 1'b1, 3, "napot_top"};
        tbl[8]  = '{48'h5000, 3'd0, 1'b0, 8, "napot_miss"};
        tbl[9]  = '{48'h6003, 3'd2, 1'b1, 4, "na4"};
        tbl[10] = '{48'h6004, 3'd0, 1'b0, 8, "na4_miss"};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset outputs", {rsp_valid_o, rsp_patid_o, rsp_hit_o, busy_o}, 6'b0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready after reset", {req_ready_o, cfg_gnt_o}, 2'b11);

        lookup(48'h1000, 3'd0, 1'b0, 8, "empty_miss", 1);

        cfg(3'd0, 48'h1000, 2'd1, 3'd3);
        cfg(3'd1, 48'h2000, 2'd1, 3'd5);
        cfg(3'd2, 48'h47FF, 2'd3, 3'd6);
        cfg(3'd3, 48'h6000, 2'd2, 3'd2);
        for (int i = 0; i < 11; i++)
            lookup(tbl[i].addr, tbl[i].patid, tbl[i].hit, tbl[i].lat, tbl[i].name, 1);

        cfg(3'd0, 48'h1000, 2'd1, 3'd1);
        cfg(3'd2, 48'h07FF, 2'd3, 3'd6);
        lookup(48'h0100, 3'd1, 1'b1, 1, "overlap_lowest", 1);

        // write (e0 -> OFF) and accept in the same cycle: the scan must see e0 already off
        cfg_we_i = 1'b1; cfg_idx_i = 3'd0; cfg_addr_i = 48'h1000; cfg_mode_i = 2'd0; cfg_patid_i = 3'd1;
        lookup(48'h0100, 3'd6, 1'b1, 3, "wr_and_accept", 1);

        rsp_ready_i = 1'b0;
        lookup(48'h0100, 3'd6, 1'b1, 3, "bp", 0);
        cfg_we_i = 1'b1; cfg_idx_i = 3'd0; cfg_addr_i = 48'h1000; cfg_mode_i = 2'd1; cfg_patid_i = 3'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check("bp held", {rsp_valid_o, rsp_patid_o, rsp_hit_o, req_ready_o, cfg_gnt_o},
                  {1'b1, 3'd6, 1'b1, 1'b0, 1'b0});
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("bp released", {rsp_valid_o, cfg_gnt_o}, 2'b01);
        @(posedge clk_i); #1;
        cfg_we_i = 1'b0;
        @(negedge clk_i);
        lookup(48'h0100, 3'd7, 1'b1, 1, "bp_cfg_landed", 1);

        req_valid_i = 1'b1; req_addr_i = 48'h9000;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("scan busy", {busy_o, req_ready_o, cfg_gnt_o}, 3'b100);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("scan idx3 busy", {busy_o, rsp_valid_o}, 2'b10);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("mid-scan reset", {rsp_valid_o, busy_o, req_ready_o, cfg_gnt_o, rsp_hit_o}, 5'b00110);
        rst_i = 1'b0;
        lookup(48'h0100, 3'd0, 1'b0, 8, "table_cleared", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
